// File: rtl/hash_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : hash_req_arb
// Description : Round-robin, block-granular arbiter sharing one hash_gen
//               engine among N_REQ requesters. Accepted beats are registered
//               into the engine, finished hashes are tagged with the owning
//               requester ID and buffered in a show-ahead result FIFO.
//               Result slots are reserved when a block is admitted, because
//               the engine cannot be stalled.
//               Optional macro HASH_ARB_PROTO_CHK_EN adds err_o and forces the
//               start bit on beats that open a block without it.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_req_arb #(
  parameter int N_REQ     = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*128-1:0]       req_data_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [127:0]               hg_data_o,
  output logic                       hg_valid_o,
  input  logic [127:0]               hg_data_i,
  input  logic                       hg_valid_i,
  output logic [127:0]               res_data_o,
  output logic [$clog2(N_REQ)-1:0]   res_id_o,
  output logic                       res_valid_o,
  input  logic                       res_ready_i
`ifdef HASH_ARB_PROTO_CHK_EN
  ,
  output logic                       err_o
`endif
);

  localparam int IDW         = $clog2(N_REQ);
  localparam int C_RAW       = $clog2(RES_DEPTH);
  localparam int C_TAG_DEPTH = 4;
  localparam int C_RSW       = C_RAW + 4;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  // FSM and arbitration state
  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;

  // Engine drive registers
  logic             hg_valid_q;
  logic [127:0]     hg_data_q;

  // Tag queue (owner IDs of blocks in flight through the engine)
  logic [IDW-1:0]   tag_mem [C_TAG_DEPTH];
  logic [1:0]       tag_wr_q, tag_rd_q;
  logic [2:0]       tag_cnt_q;

  // Result FIFO
  logic [127:0]     res_data_mem [RES_DEPTH];
  logic [IDW-1:0]   res_id_mem   [RES_DEPTH];
  logic [C_RAW-1:0] res_wr_q, res_rd_q;
  logic [C_RAW:0]   res_cnt_q;

  // Combinational wires
  logic [C_RSW-1:0] w_reserved;
  logic             w_credit;
  logic             w_win_found;
  logic [IDW-1:0]   w_win_id;
  logic [IDW:0]     w_scan_idx;
  logic [IDW-1:0]   w_sel_id;
  logic [127:0]     w_sel_data;
  logic [127:0]     w_fwd_data;
  logic             w_acc;
  logic             w_beat_end;
  logic             w_tag_push;
  logic             w_tag_pop;
  logic             w_res_pop;

  function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] x);
    return (x == IDW'(N_REQ - 1)) ? '0 : x + IDW'(1);
  endfunction

  // Slots already promised: buffered results, blocks inside the engine, and
  // the block currently being streamed. Tag-queue room is also required so
  // that deeper result FIFOs cannot overrun the fixed-depth tag queue.
  assign w_reserved = C_RSW'(res_cnt_q) + C_RSW'(tag_cnt_q) + C_RSW'(state_q == S_BURST);
  assign w_credit   = (w_reserved < C_RSW'(RES_DEPTH)) && (tag_cnt_q < 3'(C_TAG_DEPTH));

  // Round-robin scan: first valid requester at or after rr_ptr, with wrap
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (w_scan_idx >= (IDW+1)'(N_REQ)) begin
        w_scan_idx = w_scan_idx - (IDW+1)'(N_REQ);
      end
      if (!w_win_found && req_valid_i[w_scan_idx[IDW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_id    = w_scan_idx[IDW-1:0];
      end
    end
  end

  assign w_sel_id   = (state_q == S_BURST) ? owner_q : w_win_id;
  assign w_sel_data = req_data_i[128*int'(w_sel_id) +: 128];
  assign w_acc      = |(req_ready_o & req_valid_i);
  assign w_beat_end = w_sel_data[8];

  // FSM output: grant is one-hot on the owner in BURST, on the winner in IDLE
  always_comb begin
    req_ready_o = '0;
    if (rst_n) begin
      if (state_q == S_BURST) begin
        req_ready_o[owner_q] = 1'b1;
      end else if (w_credit && w_win_found) begin
        req_ready_o[w_win_id] = 1'b1;
      end
    end
  end

  // FSM next state: admit a block in IDLE, hold the owner until its end beat
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (w_acc) begin
          if (w_beat_end) begin
            rr_ptr_d = f_next(w_win_id);
          end else begin
            owner_d = w_win_id;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (w_acc && w_beat_end) begin
          rr_ptr_d = f_next(owner_q);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat forwarded to the engine; a block-opening beat may get its start bit forced
  always_comb begin
    w_fwd_data = w_sel_data;
`ifdef HASH_ARB_PROTO_CHK_EN
    if (state_q == S_IDLE) begin
      w_fwd_data[9] = 1'b1;
    end
`endif
  end

  // FSM state register plus the registered engine drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hg_valid_q <= 1'b0;
      hg_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hg_valid_q <= w_acc;
      if (w_acc) begin
        hg_data_q <= w_fwd_data;
      end
    end
  end

  assign hg_valid_o = hg_valid_q;
  assign hg_data_o  = hg_data_q;

  // Stray engine results (no tag waiting) are dropped without touching the queues
  assign w_tag_push = w_acc && w_beat_end;
  assign w_tag_pop  = hg_valid_i && (tag_cnt_q != 3'd0);
  assign w_res_pop  = res_valid_o && res_ready_i;

  // Tag queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (w_tag_push) tag_wr_q <= tag_wr_q + 2'd1;
      if (w_tag_pop)  tag_rd_q <= tag_rd_q + 2'd1;
      case ({w_tag_push, w_tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 3'd1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 3'd1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
    end
  end

  // Tag queue storage
  always_ff @(posedge clk) begin
    if (w_tag_push) begin
      tag_mem[tag_wr_q] <= w_sel_id;
    end
  end

  // Result FIFO pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (w_tag_pop) res_wr_q <= res_wr_q + C_RAW'(1);
      if (w_res_pop) res_rd_q <= res_rd_q + C_RAW'(1);
      case ({w_tag_pop, w_res_pop})
        2'b10:   res_cnt_q <= res_cnt_q + (C_RAW+1)'(1);
        2'b01:   res_cnt_q <= res_cnt_q - (C_RAW+1)'(1);
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

  // Result FIFO storage: hash tagged with the owner at the tag-queue head
  always_ff @(posedge clk) begin
    if (w_tag_pop) begin
      res_data_mem[res_wr_q] <= hg_data_i;
      res_id_mem[res_wr_q]   <= tag_mem[tag_rd_q];
    end
  end

  // Head is gated so the outputs read zero whenever the FIFO is empty
  assign res_valid_o = (res_cnt_q != '0);
  assign res_data_o  = res_valid_o ? res_data_mem[res_rd_q] : '0;
  assign res_id_o    = res_valid_o ? res_id_mem[res_rd_q]   : '0;

`ifdef HASH_ARB_PROTO_CHK_EN
  logic err_q;

  // Sticky protocol error: missing start bit on a block-opening beat, or a stray engine result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((w_acc && (state_q == S_IDLE) && !w_sel_data[9]) ||
                 (hg_valid_i && (tag_cnt_q == 3'd0))) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hash_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hash_req_arb
// Description : Self-checking bench for hash_req_arb with a behavioural
//               hash_gen engine and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_req_arb;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid_i;
  logic [N*128-1:0] req_data_i;
  logic [N-1:0]     req_ready_o;
  logic [127:0]     hg_data_o;
  logic             hg_valid_o;
  logic [127:0]     hg_data_i;
  logic             hg_valid_i;
  logic [127:0]     res_data_o;
  logic [1:0]       res_id_o;
  logic             res_valid_o;
  logic             res_ready_i;
`ifdef HASH_ARB_PROTO_CHK_EN
  logic             err_o;
`endif

  always #5 clk = ~clk;

  hash_req_arb #(.N_REQ(N), .RES_DEPTH(DEPTH)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .hg_data_o   (hg_data_o),
    .hg_valid_o  (hg_valid_o),
    .hg_data_i   (hg_data_i),
    .hg_valid_i  (hg_valid_i),
    .res_data_o  (res_data_o),
    .res_id_o    (res_id_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i)
`ifdef HASH_ARB_PROTO_CHK_EN
    ,
    .err_o       (err_o)
`endif
  );

  function automatic logic [127:0] rotl1(input logic [127:0] x);
    return {x[126:0], x[127]};
  endfunction

  // Behavioural hash_gen: chain restarts on bit 9, result 1 cycle after the end beat
  logic [127:0] eng_h;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hg_valid_i <= 1'b0;
      hg_data_i  <= '0;
      eng_h      <= '0;
    end else begin
      hg_valid_i <= hg_valid_o && hg_data_o[8];
      if (hg_valid_o) begin
        eng_h     <= hg_data_o[9] ? hg_data_o : (rotl1(eng_h) ^ hg_data_o);
        hg_data_i <= hg_data_o[9] ? hg_data_o : (rotl1(eng_h) ^ hg_data_o);
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-requester pending beats and per-block expected hashes
  logic [127:0] bq [N][64];
  int           bh [N];
  int           bt [N];
  logic [127:0] hq [N][16];
  int           hh [N];
  int           ht [N];

  typedef struct {
    int           id;
    logic [127:0] h;
    int           at;
  } res_t;
  res_t expq[$];

  // Reference model state: transaction-level view of the arbiter
  int           rr;
  int           owner;
  int           in_flight;
  int           cyc;
  logic         exp_hg_v;
  logic [127:0] exp_hg_d;
  int           vprob;
  int           rprob;
  int           acc_cnt;

  task automatic gen_block(input int r, input int len, input bit start_ok);
    logic [127:0] b, fb, h;
    h = '0;
    for (int i = 0; i < len; i++) begin
      b    = {$urandom(), $urandom(), $urandom(), $urandom()};
      b[9] = (i == 0) && start_ok;
      b[8] = (i == len - 1);
      fb   = b;
      if (i == 0) fb[9] = 1'b1;
      h = (i == 0) ? fb : (rotl1(h) ^ b);
      bq[r][bt[r] % 64] = b;
      bt[r]++;
    end
    hq[r][ht[r] % 16] = h;
    ht[r]++;
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (bh[r] != bt[r]) begin
        req_data_i[128*r +: 128] = bq[r][bh[r] % 64];
        req_valid_i[r]           = (int'($urandom_range(99)) < vprob);
      end else begin
        req_data_i[128*r +: 128] = '0;
        req_valid_i[r]           = 1'b0;
      end
    end
    res_ready_i = (int'($urandom_range(99)) < rprob);
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] m;
    m = '0;
    if (owner >= 0) begin
      m[owner] = 1'b1;
    end else if (in_flight < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid_i[(rr + k) % N]) begin
          m[(rr + k) % N] = 1'b1;
          break;
        end
      end
    end
    return m;
  endfunction

  function automatic bit busy();
    bit b;
    b = (owner >= 0) || (expq.size() > 0);
    for (int r = 0; r < N; r++) if (bh[r] != bt[r]) b = 1'b1;
    return b;
  endfunction

  // One clock: compare at the negative edge, update the model after the active edge
  task automatic step();
    logic [N-1:0] er;
    logic [127:0] b;
    res_t         t;
    int           a;
    bit           pop;
    @(negedge clk);
    er = model_ready();
    check("req_ready", 128'(req_ready_o), 128'(er));
    acc_cnt += $countones(req_ready_o & req_valid_i);
    check("hg_valid", 128'(hg_valid_o), 128'(exp_hg_v));
    if (exp_hg_v) check("hg_data", hg_data_o, exp_hg_d);
    pop = 1'b0;
    if (expq.size() > 0 && expq[0].at <= cyc) begin
      check("res_valid", 128'(res_valid_o), 128'(1));
      check("res_id", 128'(res_id_o), 128'(expq[0].id));
      check("res_data", res_data_o, expq[0].h);
      pop = res_ready_i;
    end else begin
      check("res_valid", 128'(res_valid_o), 128'(0));
    end
    a = -1;
    for (int r = 0; r < N; r++) if (er[r] && req_valid_i[r]) a = r;
    @(posedge clk);
    #1;
    cyc++;
    exp_hg_v = 1'b0;
    if (pop) begin
      void'(expq.pop_front());
      in_flight--;
    end
    if (a >= 0) begin
      b = bq[a][bh[a] % 64];
      bh[a]++;
      exp_hg_v = 1'b1;
      exp_hg_d = b;
      if (owner < 0) begin
        in_flight++;
`ifdef HASH_ARB_PROTO_CHK_EN
        exp_hg_d[9] = 1'b1;
`endif
      end
      if (b[8]) begin
        t.id = a;
        t.h  = hq[a][hh[a] % 16];
        t.at = cyc + 2;
        expq.push_back(t);
        hh[a]++;
        rr    = (a + 1) % N;
        owner = -1;
      end else begin
        owner = a;
      end
    end
    drive();
  endtask

  task automatic drain();
    int n;
    n     = 0;
    vprob = 100;
    rprob = 100;
    drive();
    while (busy() && n < 300) begin
      step();
      n++;
    end
    check("drain_done", 128'(busy()), 128'(0));
  endtask

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      bh[r] = bt[r];
      hh[r] = ht[r];
    end
    expq.delete();
    rr        = 0;
    owner     = -1;
    in_flight = 0;
    exp_hg_v  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < N; r++) begin
      bh[r] = 0; bt[r] = 0; hh[r] = 0; ht[r] = 0;
    end
    rr = 0; owner = -1; in_flight = 0; cyc = 0; acc_cnt = 0;
    exp_hg_v = 1'b0; exp_hg_d = '0; vprob = 100; rprob = 100;
    rst_n       = 1'b0;
    req_valid_i = '1;
    req_data_i  = '0;
    res_ready_i = 1'b0;

    // Reset state, with all requesters valid to show the grant is suppressed
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 128'(req_ready_o), 128'(0));
    check("rst_hg_valid", 128'(hg_valid_o), 128'(0));
    check("rst_hg_data", hg_data_o, 128'(0));
    check("rst_res_valid", 128'(res_valid_o), 128'(0));
    check("rst_res_id", 128'(res_id_o), 128'(0));
    check("rst_res_data", res_data_o, 128'(0));
`ifdef HASH_ARB_PROTO_CHK_EN
    check("rst_err", 128'(err_o), 128'(0));
`endif
    req_valid_i = '0;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;

    // Requesters 1 and 3 compete from rr_ptr = 0
    gen_block(1, 1, 1'b1);
    gen_block(3, 1, 1'b1);
    drain();

    // Requester 0 three-beat block
    gen_block(0, 3, 1'b1);
    drain();

    // Requester 2 waits while requester 0 holds a four-beat block
    vprob = 100;
    gen_block(0, 4, 1'b1);
    drive();
    step();
    gen_block(2, 1, 1'b1);
    drive();
    drain();

    // Credit exhaustion with the result FIFO stalled
    vprob = 100;
    rprob = 0;
    for (int i = 0; i < 6; i++) gen_block(1, 1, 1'b1);
    drive();
    acc_cnt = 0;
    repeat (10) step();
    check("credit_limit", 128'(acc_cnt), 128'(4));
    rprob = 100;
    drive();
    step();
    rprob = 0;
    drive();
    step();
    check("credit_refill", 128'(acc_cnt), 128'(5));
    drain();

    // Randomized traffic with random valid and result backpressure
    vprob = 70;
    rprob = 60;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if (bh[r] == bt[r] && $urandom_range(3) == 0) gen_block(r, int'($urandom_range(1, 4)), 1'b1);
      end
      drive();
      step();
    end
    drain();

    // Reset in the middle of a four-beat block
    vprob = 100;
    rprob = 100;
    gen_block(0, 4, 1'b1);
    drive();
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(req_ready_o), 128'(0));
    check("mid_rst_hg_valid", 128'(hg_valid_o), 128'(0));
    check("mid_rst_hg_data", hg_data_o, 128'(0));
    check("mid_rst_res_valid", 128'(res_valid_o), 128'(0));
    check("mid_rst_res_id", 128'(res_id_o), 128'(0));
    check("mid_rst_res_data", res_data_o, 128'(0));
    model_reset();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gen_block(3, 2, 1'b1);
    drain();

`ifdef HASH_ARB_PROTO_CHK_EN
    // Block opened without its start bit
    gen_block(2, 2, 1'b0);
    drive();
    step();
    step();
    check("err_set", 128'(err_o), 128'(1));
    drain();
    check("err_sticky", 128'(err_o), 128'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
